req_qualify_arb: RTL and testbench
==================================

# req_qualify_arb

Receive-side front end for the dynamic shared cache's 16 per-port request lines. The protocol is level-based: a requester raises its line and holds it for at least MIN_HIGH consecutive clock cycles. This block checks that each line is held long enough and records each valid request as pending. It flags and counts pulses that are too short, and issues pending requests one at a time to the cache controller through a round-robin valid/ready output.

## Interface
- NUM_CH, 16, number of request lines.
- MIN_HIGH, 5, minimum consecutive high samples for a valid request (≥2).
- CNT_W, 8, width of the violation counter.
- CH_W, $clog2(NUM_CH), width of the channel index (derived).

- clk  in  1  rising-edge clock; only clock.
- rst  in  1  asynchronous, active-high reset.
- req_in  in  NUM_CH  per-channel request levels, synchronous to clk.
- out_valid  out  1  grant valid.
- out_ready  in  1  consumer accepts the grant when out_valid && out_ready.
- out_ch  out  CH_W  granted channel index.
- pending  out  NUM_CH  per-channel qualified, ungranted request flags.
- viol_pulse  out  NUM_CH  one-cycle short-pulse violation strobe per channel.
- viol_cnt  out  CNT_W  saturating total violation count; port present only with REQ_VIOL_CNT_EN.

## Operation
- Each channel has a run counter run[i]:
  - Width is $clog2(MIN_HIGH+1).
  - It increments on each edge where req_in[i]=1 and saturates at MIN_HIGH.
  - It clears to 0 on each edge where req_in[i]=0.
- Qualify event:
  - Occurs on the edge where req_in[i]=1 and run[i]==MIN_HIGH-1, i.e. the MIN_HIGH-th consecutive high sample.
  - pending[i] is set on that edge.
  - There is exactly one qualify event per high run, however long the line stays high.
- Violation event:
  - Occurs on the edge where req_in[i]=0 and 0<run[i]<MIN_HIGH.
  - viol_pulse[i]=1 for exactly the following cycle.
  - No pending is set for that run.
- Qualify while pending[i] is already 1: the two requests merge, pending stays 1 and no error is raised.
- Output register (out_valid, out_ch):
  - It may load when out_valid==0 or a handshake occurs this cycle.
  - On load, if any pending bit is set, the arbiter selects the first set bit searching from ptr+1 upward, wrapping from NUM_CH-1 to 0.
  - The load sets out_valid=1 and out_ch to the selected channel, clears that pending bit, and sets ptr to the selected channel.
  - If no pending bit is set, out_valid goes to 0.
- ptr resets to NUM_CH-1, so channel 0 has first priority.
- Same-edge set and clear on one channel (a new qualify and a grant of that channel): set wins, and pending stays 1.
- While out_valid=1 and out_ready=0, out_valid and out_ch are held stable.

## Timing
- Reset values: out_valid=0, out_ch=0, pending=0, viol_pulse=0, viol_cnt=0, all run counters 0, ptr=NUM_CH-1.
- Reset is asynchronous; assertion clears all state immediately.
- Latency:
  - Edge E: MIN_HIGH-th high sample; pending[i]=1 after E.
  - Edge E+1: out_valid=1, out_ch=i, pending[i]=0, if the output register is free.
- Throughput is one grant per cycle with out_ready held at 1; back-to-back grants need no idle cycle.
- viol_pulse is registered: it is high for the cycle after the falling sample.
- Reset mid-run: partial run counts are discarded. A line held high through reset release needs MIN_HIGH fresh samples after release to qualify.
- A line high at reset release that falls before MIN_HIGH samples is a violation.

## Configuration
- REQ_VIOL_CNT_EN defined:
  - The viol_cnt port and its counter are compiled in.
  - On each edge the counter adds the number of channels with a violation event that edge.
  - It saturates at 2^CNT_W-1 and never wraps.
- REQ_VIOL_CNT_EN undefined:
  - The viol_cnt port and the counter logic are absent.
  - viol_pulse behaviour is unchanged.

## Test plan
- Ch3 high 5 cycles, then low, with out_ready=1:
  - pending[3]=1 for one cycle.
  - Next cycle out_valid=1 with out_ch=3 for exactly one cycle.
  - No viol_pulse.
- Ch7 high 3 cycles, then low:
  - viol_pulse[7]=1 for one cycle.
  - No pending and no grant.
  - viol_cnt=1 (with the macro).
  - Ch2 and ch9 both pulsing 2 cycles, falling on the same edge: viol_cnt increments by 2.
- Ch0, ch5 and ch15 qualify on the same edge, out_ready=1:
  - Grants out_ch=0, 5, 15 on consecutive cycles.
  - Ch0 and ch5 then requalify together: next grants are 0, then 5, with ptr wrapping from 15.
- Ch4 qualifies with out_ready=0 for 10 cycles:
  - out_valid=1 and out_ch=4 stay stable throughout.
  - Ch6 qualifying meanwhile leaves pending[6]=1.
  - When out_ready rises: handshake on ch4, then grant ch6.
- Ch1 held high 20 cycles: exactly one grant, and no violation on the fall.
- rst pulsed while ch8 has run=3 and out_valid=1:
  - All outputs go to 0 immediately.
  - Ch8 held high after release qualifies only on the 5th post-release sample.
- viol_cnt saturation: 300 single-channel violations with CNT_W=8 give viol_cnt=255.

Source files
------------

// File: rtl/req_qualify_arb.sv
// Request-line qualifier: minimum-high-time check, pending flags and round-robin grant register.
// Define REQ_VIOL_CNT_EN to add the saturating viol_cnt counter and port.
module req_qualify_arb #(
    parameter int NUM_CH   = 16,
    parameter int MIN_HIGH = 5,
    parameter int CNT_W    = 8,
    parameter int CH_W     = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] viol_pulse
`ifdef REQ_VIOL_CNT_EN
    ,
    output logic [CNT_W-1:0]  viol_cnt
`endif
);

    localparam int                RUN_W    = $clog2(MIN_HIGH + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(MIN_HIGH);
    localparam logic [RUN_W-1:0]  RUN_QUAL = RUN_W'(MIN_HIGH - 1);
    localparam int unsigned       NUM_CH_U = NUM_CH;

    if (MIN_HIGH < 2 || CNT_W < 1) begin : g_param_check
        $error("req_qualify_arb: MIN_HIGH must be >= 2 and CNT_W >= 1");
    end

    logic [RUN_W-1:0]  run_q [NUM_CH];
    logic [RUN_W-1:0]  run_d [NUM_CH];
    logic [NUM_CH-1:0] qual;
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] viol_pulse_q, viol_pulse_d;
    logic              out_valid_q, out_valid_d;
    logic [CH_W-1:0]   out_ch_q, out_ch_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic              load;
    logic              found;
    logic [CH_W-1:0]   sel;
    logic [31:0]       idx;

    // Per-line run counters; qualify fires only on the MIN_HIGH-th sample, so once per run.
    always_comb begin
        run_d        = run_q;
        qual         = '0;
        viol_pulse_d = '0;
        for (int unsigned i = 0; i < NUM_CH_U; i++) begin
            qual[i]         = req_in[i] && (run_q[i] == RUN_QUAL);
            viol_pulse_d[i] = !req_in[i] && (run_q[i] != '0) && (run_q[i] < RUN_MAX);
            if (!req_in[i]) begin
                run_d[i] = '0;
            end else if (run_q[i] == RUN_MAX) begin
                run_d[i] = RUN_MAX;
            end else begin
                run_d[i] = run_q[i] + 1'b1;
            end
        end
    end

    // Round-robin pick over the registered pending flags, starting just after the last grant.
    always_comb begin
        load  = !out_valid_q || out_ready;
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int unsigned k = 1; k <= NUM_CH_U; k++) begin
            idx = (32'(ptr_q) + k) % NUM_CH_U;
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                sel   = CH_W'(idx);
            end
        end
    end

    // Clear-then-set ordering lets a same-edge requalify win over the grant of that channel.
    always_comb begin
        pending_d   = pending_q;
        out_valid_d = out_valid_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = found;
            if (found) begin
                pending_d[sel] = 1'b0;
                out_ch_d       = sel;
                ptr_d          = sel;
            end
        end
        pending_d = pending_d | qual;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_CH_U; i++) begin
                run_q[i] <= '0;
            end
            pending_q    <= '0;
            viol_pulse_q <= '0;
            out_valid_q  <= 1'b0;
            out_ch_q     <= '0;
            ptr_q        <= CH_W'(NUM_CH - 1);
        end else begin
            for (int unsigned i = 0; i < NUM_CH_U; i++) begin
                run_q[i] <= run_d[i];
            end
            pending_q    <= pending_d;
            viol_pulse_q <= viol_pulse_d;
            out_valid_q  <= out_valid_d;
            out_ch_q     <= out_ch_d;
            ptr_q        <= ptr_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_ch     = out_ch_q;
    assign pending    = pending_q;
    assign viol_pulse = viol_pulse_q;

`ifdef REQ_VIOL_CNT_EN
    localparam int SUM_W = $clog2(NUM_CH + 1);
    localparam int EXT_W = CNT_W + SUM_W;

    logic [SUM_W-1:0] viol_sum;
    logic [EXT_W-1:0] cnt_ext;
    logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;

    // Adds every violation seen this edge, clamping at all-ones instead of wrapping.
    always_comb begin
        viol_sum = '0;
        for (int unsigned i = 0; i < NUM_CH_U; i++) begin
            viol_sum = viol_sum + SUM_W'(viol_pulse_d[i]);
        end
        cnt_ext = EXT_W'(viol_cnt_q) + EXT_W'(viol_sum);
        if (cnt_ext > EXT_W'({CNT_W{1'b1}})) begin
            viol_cnt_d = '1;
        end else begin
            viol_cnt_d = cnt_ext[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            viol_cnt_q <= '0;
        end else begin
            viol_cnt_q <= viol_cnt_d;
        end
    end

    assign viol_cnt = viol_cnt_q;
`endif

endmodule

// File: tb/tb_req_qualify_arb.sv
// Directed testbench for req_qualify_arb; viol_cnt checks apply when REQ_VIOL_CNT_EN is defined.
module tb_req_qualify_arb;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] req_in = '0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    logic [3:0]  out_ch;
    logic [15:0] pending;
    logic [15:0] viol_pulse;
`ifdef REQ_VIOL_CNT_EN
    logic [7:0]  viol_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    req_qualify_arb #(
        .NUM_CH   (16),
        .MIN_HIGH (5),
        .CNT_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_in     (req_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .pending    (pending),
        .viol_pulse (viol_pulse)
`ifdef REQ_VIOL_CNT_EN
        ,
        .viol_cnt   (viol_cnt)
`endif
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        req_in    = '0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_ch !== 4'd0) begin n_err++; $display("FAIL rst_ch: got %0d want 0", out_ch); end
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL rst_pending: got %h want 0000", pending); end
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL rst_viol: got %h want 0000", viol_pulse); end
`ifdef REQ_VIOL_CNT_EN
        n_cmp++; if (viol_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d want 0", viol_cnt); end
`endif
        do_reset();
    endtask

    task automatic test_qualify;
        do_reset();
        req_in[3] = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            n_cmp++; if ({out_valid, pending} !== 17'h0) begin n_err++; $display("FAIL q3_early%0d: got %h want 0", c, {out_valid, pending}); end
        end
        step(1);
        n_cmp++; if (pending !== 16'h0008) begin n_err++; $display("FAIL q3_pending: got %h want 0008", pending); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL q3_valid_early: got %b want 0", out_valid); end
        req_in = '0;
        step(1);
        n_cmp++; if ({out_valid, out_ch} !== {1'b1, 4'd3}) begin n_err++; $display("FAIL q3_grant: got v=%b ch=%0d want v=1 ch=3", out_valid, out_ch); end
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL q3_cleared: got %h want 0000", pending); end
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL q3_noviol: got %h want 0000", viol_pulse); end
        step(1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL q3_single: got %b want 0", out_valid); end
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL q3_noviol2: got %h want 0000", viol_pulse); end
    endtask

    task automatic test_violation;
        do_reset();
        req_in[7] = 1'b1;
        step(3);
        req_in = '0;
        step(1);
        n_cmp++; if (viol_pulse !== 16'h0080) begin n_err++; $display("FAIL v7_pulse: got %h want 0080", viol_pulse); end
        n_cmp++; if ({out_valid, pending} !== 17'h0) begin n_err++; $display("FAIL v7_nopend: got %h want 0", {out_valid, pending}); end
`ifdef REQ_VIOL_CNT_EN
        n_cmp++; if (viol_cnt !== 8'd1) begin n_err++; $display("FAIL v7_cnt: got %0d want 1", viol_cnt); end
`endif
        step(1);
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL v7_oneshot: got %h want 0000", viol_pulse); end
        n_cmp++; if ({out_valid, pending} !== 17'h0) begin n_err++; $display("FAIL v7_nogrant: got %h want 0", {out_valid, pending}); end
        req_in = 16'h0204;
        step(2);
        req_in = '0;
        step(1);
        n_cmp++; if (viol_pulse !== 16'h0204) begin n_err++; $display("FAIL v29_pulse: got %h want 0204", viol_pulse); end
`ifdef REQ_VIOL_CNT_EN
        n_cmp++; if (viol_cnt !== 8'd3) begin n_err++; $display("FAIL v29_cnt: got %0d want 3", viol_cnt); end
`endif
        step(1);
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL v29_oneshot: got %h want 0000", viol_pulse); end
    endtask

    task automatic test_round_robin;
        do_reset();
        req_in = 16'h8021;
        step(5);
        n_cmp++; if (pending !== 16'h8021) begin n_err++; $display("FAIL rr_pending: got %h want 8021", pending); end
        req_in = '0;
        step(1);
        n_cmp++; if ({out_valid, out_ch, pending} !== {1'b1, 4'd0, 16'h8020}) begin n_err++; $display("FAIL rr_g0: got v=%b ch=%0d p=%h want v=1 ch=0 p=8020", out_valid, out_ch, pending); end
        step(1);
        n_cmp++; if ({out_valid, out_ch, pending} !== {1'b1, 4'd5, 16'h8000}) begin n_err++; $display("FAIL rr_g5: got v=%b ch=%0d p=%h want v=1 ch=5 p=8000", out_valid, out_ch, pending); end
        step(1);
        n_cmp++; if ({out_valid, out_ch, pending} !== {1'b1, 4'd15, 16'h0000}) begin n_err++; $display("FAIL rr_g15: got v=%b ch=%0d p=%h want v=1 ch=15 p=0000", out_valid, out_ch, pending); end
        req_in = 16'h0021;
        step(5);
        n_cmp++; if ({out_valid, pending} !== {1'b0, 16'h0021}) begin n_err++; $display("FAIL rr_req: got v=%b p=%h want v=0 p=0021", out_valid, pending); end
        req_in = '0;
        step(1);
        n_cmp++; if ({out_valid, out_ch} !== {1'b1, 4'd0}) begin n_err++; $display("FAIL rr_wrap0: got v=%b ch=%0d want v=1 ch=0", out_valid, out_ch); end
        step(1);
        n_cmp++; if ({out_valid, out_ch} !== {1'b1, 4'd5}) begin n_err++; $display("FAIL rr_wrap5: got v=%b ch=%0d want v=1 ch=5", out_valid, out_ch); end
        step(1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure;
        do_reset();
        out_ready = 1'b0;
        req_in[4] = 1'b1;
        step(5);
        req_in = '0;
        step(1);
        n_cmp++; if ({out_valid, out_ch, pending} !== {1'b1, 4'd4, 16'h0000}) begin n_err++; $display("FAIL bp_load: got v=%b ch=%0d p=%h want v=1 ch=4 p=0000", out_valid, out_ch, pending); end
        req_in[6] = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step(1);
            n_cmp++; if ({out_valid, out_ch} !== {1'b1, 4'd4}) begin n_err++; $display("FAIL bp_hold%0d: got v=%b ch=%0d want v=1 ch=4", c, out_valid, out_ch); end
            if (c == 5) req_in = '0;
        end
        n_cmp++; if (pending !== 16'h0040) begin n_err++; $display("FAIL bp_pend6: got %h want 0040", pending); end
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL bp_noviol: got %h want 0000", viol_pulse); end
        out_ready = 1'b1;
        step(1);
        n_cmp++; if ({out_valid, out_ch, pending} !== {1'b1, 4'd6, 16'h0000}) begin n_err++; $display("FAIL bp_g6: got v=%b ch=%0d p=%h want v=1 ch=6 p=0000", out_valid, out_ch, pending); end
        step(1);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_idle: got %b want 0", out_valid); end
    endtask

    task automatic test_long_high;
        int grants;
        logic [15:0] viols;
        grants = 0;
        viols  = '0;
        do_reset();
        req_in[1] = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step(1);
            if (out_valid && out_ready) grants++;
            viols |= viol_pulse;
        end
        req_in = '0;
        for (int c = 0; c < 3; c++) begin
            step(1);
            if (out_valid && out_ready) grants++;
            viols |= viol_pulse;
        end
        n_cmp++; if (grants !== 1) begin n_err++; $display("FAIL long_grants: got %0d want 1", grants); end
        n_cmp++; if (viols !== 16'h0000) begin n_err++; $display("FAIL long_viol: got %h want 0000", viols); end
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL long_pending: got %h want 0000", pending); end
    endtask

    task automatic test_reset_midrun;
        do_reset();
        out_ready = 1'b0;
        req_in[4] = 1'b1;
        step(5);
        req_in = '0;
        step(1);
        n_cmp++; if ({out_valid, out_ch} !== {1'b1, 4'd4}) begin n_err++; $display("FAIL mr_pre: got v=%b ch=%0d want v=1 ch=4", out_valid, out_ch); end
        req_in[8] = 1'b1;
        step(3);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({out_valid, out_ch, pending, viol_pulse} !== 37'h0) begin n_err++; $display("FAIL mr_async: got v=%b ch=%0d p=%h vp=%h want all 0", out_valid, out_ch, pending, viol_pulse); end
`ifdef REQ_VIOL_CNT_EN
        n_cmp++; if (viol_cnt !== 8'd0) begin n_err++; $display("FAIL mr_cnt: got %0d want 0", viol_cnt); end
`endif
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            step(1);
            n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL mr_early%0d: got %h want 0000", c, pending); end
        end
        step(1);
        n_cmp++; if (pending !== 16'h0100) begin n_err++; $display("FAIL mr_qual5: got %h want 0100", pending); end
        req_in = '0;
        step(1);
        n_cmp++; if ({out_valid, out_ch} !== {1'b1, 4'd8}) begin n_err++; $display("FAIL mr_g8: got v=%b ch=%0d want v=1 ch=8", out_valid, out_ch); end
        n_cmp++; if (viol_pulse !== 16'h0000) begin n_err++; $display("FAIL mr_noviol: got %h want 0000", viol_pulse); end
        req_in = 16'h0400;
        rst    = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        step(2);
        req_in = '0;
        step(1);
        n_cmp++; if (viol_pulse !== 16'h0400) begin n_err++; $display("FAIL mr_relviol: got %h want 0400", viol_pulse); end
        n_cmp++; if (pending !== 16'h0000) begin n_err++; $display("FAIL mr_relnopend: got %h want 0000", pending); end
    endtask

`ifdef REQ_VIOL_CNT_EN
    task automatic test_saturation;
        do_reset();
        repeat (254) begin
            req_in[7] = 1'b1;
            step(1);
            req_in = '0;
            step(1);
        end
        n_cmp++; if (viol_cnt !== 8'd254) begin n_err++; $display("FAIL sat_254: got %0d want 254", viol_cnt); end
        repeat (46) begin
            req_in[7] = 1'b1;
            step(1);
            req_in = '0;
            step(1);
        end
        n_cmp++; if (viol_cnt !== 8'd255) begin n_err++; $display("FAIL sat_300: got %0d want 255", viol_cnt); end
        req_in = 16'h0003;
        step(1);
        req_in = '0;
        step(1);
        n_cmp++; if (viol_cnt !== 8'd255) begin n_err++; $display("FAIL sat_nowrap: got %0d want 255", viol_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_qualify();
        test_violation();
        test_round_robin();
        test_backpressure();
        test_long_high();
        test_reset_midrun();
`ifdef REQ_VIOL_CNT_EN
        test_saturation();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
